// File: rtl/pkt_slot_buffer_if.sv
// Stream-in, stream-out and packet-processor signals of pkt_slot_buffer.
// slave is the buffer side; master is the side that drives the buffer.
`timescale 1ns/1ps
interface pkt_slot_buffer_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]            in_data;
  logic [CTRL_WIDTH-1:0]            in_ctrl;
  logic                             in_wr;
  logic                             in_rdy;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_wr;
  logic                             out_rdy;
  logic                             proc_bypass;
  logic                             proc_en;
  logic [ADDR_WIDTH-1:0]            proc_start_addr;
  logic [ADDR_WIDTH-1:0]            proc_end_addr;
  logic                             proc_done;
  logic [ADDR_WIDTH-1:0]            proc_addr;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] proc_wr_data;
  logic                             proc_wen;
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] proc_rd_data;

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy, proc_bypass, proc_done, proc_addr, proc_wr_data,
           proc_wen,
    input  in_rdy, out_data, out_ctrl, out_wr, proc_en, proc_start_addr, proc_end_addr,
           proc_rd_data
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy, proc_bypass, proc_done, proc_addr, proc_wr_data,
           proc_wen,
    output in_rdy, out_data, out_ctrl, out_wr, proc_en, proc_start_addr, proc_end_addr,
           proc_rd_data
  );
endinterface

// File: rtl/pkt_slot_buffer.sv
// Multi-slot store-and-forward packet buffer: packets fill ring-ordered slots of a dual-port
// memory, are optionally handed to a packet processor, then drain in arrival order.
`timescale 1ns/1ps
module pkt_slot_buffer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_SLOTS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pkt_slot_buffer_if.slave        bus,
  output logic [31:0]             o_pkt_in_count,
  output logic [31:0]             o_pkt_out_count,
  output logic [31:0]             o_pkt_drop_count
);
  localparam int unsigned MemDepth  = 2 ** ADDR_WIDTH;
  localparam int unsigned SlotDepth = MemDepth / NUM_SLOTS;
  localparam int unsigned SlotW     = $clog2(NUM_SLOTS);
  localparam int unsigned OffW      = ADDR_WIDTH - SlotW;
  localparam int unsigned WordW     = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {SlFree, SlFill, SlReady, SlProc, SlDone} slot_st_e;
  typedef logic [SlotW-1:0]      slot_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  logic [WordW-1:0] r_mem [MemDepth];
  slot_st_e         r_slot_st [NUM_SLOTS];
  addr_t            r_end_addr [NUM_SLOTS];
  slot_t            r_wr_slot, r_proc_slot, r_rd_slot;
  logic [OffW:0]    r_wptr;
  logic             r_seen_pl, r_dropping, r_live;
  logic [SlotW:0]   r_proc_cnt;
  logic             r_proc_en;
  addr_t            r_proc_start, r_proc_end;
  logic [OffW-1:0]  r_rd_ptr;
  logic             r_out_wr;
  logic [WordW-1:0] r_b_rdata;
  logic [31:0]      r_in_cnt, r_out_cnt, r_drop_cnt;

  slot_st_e w_wr_st;
  logic     w_in_rdy, w_wr_acc, w_is_ctrl, w_is_eop, w_overflow, w_wr_store, w_wr_commit;
  logic     w_proc_start, w_proc_skip, w_proc_fin, w_proc_adv;
  logic     w_rd_issue, w_rd_last;
  addr_t    w_wr_addr, w_rd_addr, w_b_addr;

  // A discarding packet leaves its slot FREE, so in_rdy stays high through the discard.
  assign w_wr_st     = r_slot_st[r_wr_slot];
  assign w_in_rdy    = r_live && (r_dropping || w_wr_st == SlFree || w_wr_st == SlFill);
  assign w_wr_acc    = bus.in_wr && w_in_rdy;
  assign w_is_ctrl   = |bus.in_ctrl;
  assign w_is_eop    = w_is_ctrl && r_seen_pl;
  assign w_overflow  = r_wptr == (OffW + 1)'(SlotDepth);
  assign w_wr_store  = w_wr_acc && !r_dropping && !w_overflow;
  assign w_wr_commit = w_wr_store && w_is_eop;
  assign w_wr_addr   = {r_wr_slot, r_wptr[OffW-1:0]};

  // r_proc_cnt = slots committed but not yet passed by proc_slot; disambiguates a full ring.
  assign w_proc_start = !r_proc_en && r_proc_cnt != '0 && r_slot_st[r_proc_slot] == SlReady;
  assign w_proc_skip  = !r_proc_en && r_proc_cnt != '0 && r_slot_st[r_proc_slot] == SlDone;
  assign w_proc_fin   = r_proc_en && bus.proc_done;
  assign w_proc_adv   = w_proc_skip || w_proc_fin;

  // Reader never overtakes proc_slot, so a bypassed slot is freed only after it is skipped.
  assign w_rd_addr  = {r_rd_slot, r_rd_ptr};
  assign w_rd_last  = w_rd_addr == r_end_addr[r_rd_slot];
  assign w_rd_issue = r_slot_st[r_rd_slot] == SlDone && bus.out_rdy && !r_proc_en &&
                      (r_rd_slot != r_proc_slot || r_proc_cnt == '0);
  assign w_b_addr   = r_proc_en ? bus.proc_addr : w_rd_addr;

  always_ff @(posedge clk) begin
    if (w_wr_store) r_mem[w_wr_addr] <= {bus.in_ctrl, bus.in_data};
    if (r_proc_en && bus.proc_wen) r_mem[bus.proc_addr] <= bus.proc_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        r_slot_st[i]  <= SlFree;
        r_end_addr[i] <= '0;
      end
      r_wr_slot    <= '0;
      r_proc_slot  <= '0;
      r_rd_slot    <= '0;
      r_wptr       <= '0;
      r_seen_pl    <= 1'b0;
      r_dropping   <= 1'b0;
      r_live       <= 1'b0;
      r_proc_cnt   <= '0;
      r_proc_en    <= 1'b0;
      r_proc_start <= '0;
      r_proc_end   <= '0;
      r_rd_ptr     <= '0;
      r_out_wr     <= 1'b0;
      r_b_rdata    <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_live <= 1'b1;

      if (w_wr_acc) begin
        if (r_dropping || w_overflow) begin
          r_wptr <= '0;
          if (!r_dropping) r_slot_st[r_wr_slot] <= SlFree;
          if (w_is_eop) begin
            r_dropping <= 1'b0;
            r_seen_pl  <= 1'b0;
            r_drop_cnt <= r_drop_cnt + 32'd1;
          end else begin
            r_dropping <= 1'b1;
            if (!w_is_ctrl) r_seen_pl <= 1'b1;
          end
        end else if (w_is_eop) begin
          r_end_addr[r_wr_slot] <= w_wr_addr;
          r_slot_st[r_wr_slot]  <= bus.proc_bypass ? SlDone : SlReady;
          r_wr_slot             <= r_wr_slot + slot_t'(1);
          r_wptr                <= '0;
          r_seen_pl             <= 1'b0;
          r_in_cnt              <= r_in_cnt + 32'd1;
        end else begin
          r_slot_st[r_wr_slot] <= SlFill;
          r_wptr               <= r_wptr + (OffW + 1)'(1);
          if (!w_is_ctrl) r_seen_pl <= 1'b1;
        end
      end

      if (w_proc_start) begin
        r_slot_st[r_proc_slot] <= SlProc;
        r_proc_en              <= 1'b1;
        r_proc_start           <= {r_proc_slot, OffW'(0)};
        r_proc_end             <= r_end_addr[r_proc_slot];
      end
      if (w_proc_fin) begin
        r_slot_st[r_proc_slot] <= SlDone;
        r_proc_en              <= 1'b0;
      end
      if (w_proc_adv) r_proc_slot <= r_proc_slot + slot_t'(1);
      r_proc_cnt <= r_proc_cnt + {SlotW'(0), w_wr_commit} - {SlotW'(0), w_proc_adv};

      r_out_wr <= w_rd_issue;
      if (w_rd_issue) begin
        if (w_rd_last) begin
          r_slot_st[r_rd_slot] <= SlFree;
          r_rd_slot            <= r_rd_slot + slot_t'(1);
          r_rd_ptr             <= '0;
          r_out_cnt            <= r_out_cnt + 32'd1;
        end else begin
          r_rd_ptr <= r_rd_ptr + OffW'(1);
        end
      end
      r_b_rdata <= r_mem[w_b_addr];
    end
  end

  assign bus.in_rdy          = w_in_rdy;
  assign bus.out_wr          = r_out_wr;
  assign bus.out_data        = r_b_rdata[DATA_WIDTH-1:0];
  assign bus.out_ctrl        = r_b_rdata[WordW-1 -: CTRL_WIDTH];
  assign bus.proc_rd_data    = r_b_rdata;
  assign bus.proc_en         = r_proc_en;
  assign bus.proc_start_addr = r_proc_start;
  assign bus.proc_end_addr   = r_proc_end;
  assign o_pkt_in_count      = r_in_cnt;
  assign o_pkt_out_count     = r_out_cnt;
  assign o_pkt_drop_count    = r_drop_cnt;
endmodule
